// File: rtl/pc_sequencer_if.sv
// Memory request/response bundle between the control sequencer and instruction/data memory.
// The sequencer is the master; the memory is the slave.
interface pc_sequencer_if #(
    parameter int INSTR_WIDTH = 16
);
    logic                   mem_req;
    logic                   mem_we;
    logic                   addr_sel;
    logic [INSTR_WIDTH-1:0] instr;
    logic                   mem_rdy;

    modport master (
        output mem_req,
        output mem_we,
        output addr_sel,
        input  instr,
        input  mem_rdy
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  addr_sel,
        output instr,
        output mem_rdy
    );
endinterface

// File: rtl/pc_sequencer.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB control FSM for the 8-bit RISC core, with a memory
// wait timeout and a sticky fault flag. Strobes are decoded from state, opcode and handshake.
module pc_sequencer #(
    parameter int INSTR_WIDTH = 16,
    parameter int WAIT_MAX    = 15,
    parameter int WCNT_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  zflag,
    pc_sequencer_if.master        bus,
    output logic                  loadir,
    output logic                  loadpc,
    output logic                  msel,
    output logic                  alu_en,
    output logic                  rf_we,
    output logic                  halted,
    output logic                  err,
    output logic [2:0]            state_o
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        HALT   = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        OP_ALU   = 3'b000,
        OP_LOAD  = 3'b001,
        OP_STORE = 3'b010,
        OP_BR    = 3'b011,
        OP_BZ    = 3'b100,
        OP_ILL5  = 3'b101,
        OP_ILL6  = 3'b110,
        OP_HALT  = 3'b111
    } opcode_t;

    localparam bit                  TIMEOUT_EN = (WAIT_MAX != 0);
    localparam logic [WCNT_WIDTH-1:0] WAIT_LIM = WCNT_WIDTH'(WAIT_MAX);

    state_t                state, state_d;
    opcode_t               opcode;
    logic [WCNT_WIDTH-1:0] wait_cnt, wait_d;
    logic                  err_q;
    logic                  err_set;
    logic                  fetch_done;
    logic                  timeout;

    // Only the opcode field is consumed here; the full word goes to the external IR.
    logic unused_instr_bits;
    assign unused_instr_bits = ^bus.instr[INSTR_WIDTH-4:0];

    assign fetch_done = (state == FETCH) && bus.mem_rdy;
    // A ready in the limit cycle still completes the request, so timeout needs mem_rdy=0.
    assign timeout    = TIMEOUT_EN && !bus.mem_rdy && (wait_cnt == WAIT_LIM);

    // State register, plus the opcode copy, wait counter and sticky fault.
    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            // NOTE: opcode is reset too even though it is always written before use,
            // so the strobe decode never sees X after reset.
            opcode   <= OP_ALU;
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_d;
            wait_cnt <= wait_d;
            if (err_set)
                err_q <= 1'b1;
            if (fetch_done)
                opcode <= opcode_t'(bus.instr[INSTR_WIDTH-1 -: 3]);
        end
    end

    // Next-state and wait-counter logic.
    // NOTE: every variable driven here gets a default first, otherwise a missed branch
    // would infer a latch.
    always_comb begin
        state_d = state;
        wait_d  = wait_cnt;
        err_set = 1'b0;
        case (state)
            IDLE: begin
                if (start)
                    state_d = FETCH;
            end
            FETCH: begin
                if (bus.mem_rdy) begin
                    state_d = DECODE;
                end else if (timeout) begin
                    err_set = 1'b1;
                    state_d = HALT;
                end else begin
                    wait_d = wait_cnt + 1'b1;
                end
            end
            DECODE: state_d = EXEC;
            EXEC: begin
                case (opcode)
                    OP_ALU:            state_d = WB;
                    OP_LOAD, OP_STORE: state_d = MEM;
                    OP_BR, OP_BZ:      state_d = FETCH;
                    OP_HALT:           state_d = HALT;
                    default: begin
                        err_set = 1'b1;
                        state_d = HALT;
                    end
                endcase
            end
            MEM: begin
                if (bus.mem_rdy) begin
                    state_d = (opcode == OP_LOAD) ? WB : FETCH;
                end else if (timeout) begin
                    err_set = 1'b1;
                    state_d = HALT;
                end else begin
                    wait_d = wait_cnt + 1'b1;
                end
            end
            WB:      state_d = FETCH;
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase
        if (state_d != state)
            wait_d = '0;
    end

    // Output strobe decode.
    always_comb begin
        bus.mem_req  = 1'b0;
        bus.mem_we   = 1'b0;
        bus.addr_sel = 1'b0;
        loadir       = 1'b0;
        loadpc       = 1'b0;
        msel         = 1'b0;
        alu_en       = 1'b0;
        rf_we        = 1'b0;
        halted       = 1'b0;
        case (state)
            FETCH: begin
                bus.mem_req = 1'b1;
                if (bus.mem_rdy) begin
                    loadir = 1'b1;
                    loadpc = 1'b1;
                end
            end
            EXEC: begin
                alu_en = 1'b1;
                if (opcode == OP_BR || (opcode == OP_BZ && zflag)) begin
                    loadpc = 1'b1;
                    msel   = 1'b1;
                end
            end
            MEM: begin
                bus.mem_req  = 1'b1;
                bus.addr_sel = 1'b1;
                bus.mem_we   = (opcode == OP_STORE);
            end
            WB:      rf_we  = 1'b1;
            HALT:    halted = 1'b1;
            default: ;
        endcase
    end

    assign err     = err_q;
    assign state_o = state;

    // A pending request is never withdrawn except by a timeout fault.
    assert property (@(posedge clk) disable iff (reset)
        (bus.mem_req && !bus.mem_rdy && !timeout) |=> bus.mem_req);

    // Fetch completion increments the PC; it never takes the branch source.
    assert property (@(posedge clk) disable iff (reset)
        loadir |-> (loadpc && !msel));

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: per-instruction expected cycle traces are built from
// the instruction-level latency rules, with randomized waits, zflag and don't-care inputs.
module tb_pc_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       zflag;
    logic       loadir, loadpc, msel, alu_en, rf_we, halted, err;
    logic [2:0] state_o;

    int n_checks = 0;
    int n_fail   = 0;

    pc_sequencer_if #(.INSTR_WIDTH(16)) bus ();

    pc_sequencer #(
        .INSTR_WIDTH(16),
        .WAIT_MAX   (15),
        .WCNT_WIDTH (4)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .zflag  (zflag),
        .bus    (bus),
        .loadir (loadir),
        .loadpc (loadpc),
        .msel   (msel),
        .alu_en (alu_en),
        .rf_we  (rf_we),
        .halted (halted),
        .err    (err),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic        rdy;
        logic        z;
        logic [15:0] instr;
        logic [12:0] exp;
        string       tag;
    } cyc_t;

    cyc_t trace[$];

    // Packed order: state, mem_req, mem_we, addr_sel, loadir, loadpc, msel, alu_en, rf_we, halted, err
    function automatic logic [12:0] vec(input logic [2:0] st, input logic req, input logic we,
                                        input logic asel, input logic lir, input logic lpc,
                                        input logic ms, input logic alu, input logic rfw,
                                        input logic hlt, input logic er);
        return {st, req, we, asel, lir, lpc, ms, alu, rfw, hlt, er};
    endfunction

    function automatic logic [12:0] observed();
        return {state_o, bus.mem_req, bus.mem_we, bus.addr_sel, loadir, loadpc, msel,
                alu_en, rf_we, halted, err};
    endfunction

    task automatic push(input logic st, input logic rdy, input logic z, input logic [15:0] ins,
                        input logic [12:0] e, input string tag);
        cyc_t c;
        c.start = st;
        c.rdy   = rdy;
        c.z     = z;
        c.instr = ins;
        c.exp   = e;
        c.tag   = tag;
        trace.push_back(c);
    endtask

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic logic [15:0] rw();
        return 16'($urandom);
    endfunction

    task automatic push_start();
        push(1'b1, rb(), rb(), rw(), vec(3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "idle_start");
    endtask

    // Expected cycles of one instruction, FETCH through the cycle before the next FETCH.
    task automatic add_instr(input logic [2:0] op, input int fw, input int mw, input logic z);
        logic take;
        logic ill;
        for (int i = 0; i < fw; i++)
            push(rb(), 1'b0, rb(), rw(), vec(3'd1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "fetch_wait");
        push(rb(), 1'b1, rb(), {op, 13'($urandom)},
             vec(3'd1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0), "fetch_done");
        push(rb(), rb(), rb(), rw(), vec(3'd2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "decode");
        take = (op == 3'd3) || (op == 3'd4 && z);
        push(rb(), rb(), z, rw(), vec(3'd3, 0, 0, 0, 0, take, take, 1, 0, 0, 0), "exec");
        if (op == 3'd1 || op == 3'd2) begin
            for (int i = 0; i < mw; i++)
                push(rb(), 1'b0, rb(), rw(),
                     vec(3'd4, 1, op == 3'd2, 1, 0, 0, 0, 0, 0, 0, 0), "mem_wait");
            push(rb(), 1'b1, rb(), rw(),
                 vec(3'd4, 1, op == 3'd2, 1, 0, 0, 0, 0, 0, 0, 0), "mem_done");
        end
        if (op == 3'd0 || op == 3'd1)
            push(rb(), rb(), rb(), rw(), vec(3'd5, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), "wb");
        if (op >= 3'd5) begin
            ill = (op != 3'd7);
            for (int i = 0; i < 4; i++)
                push(1'b1, rb(), rb(), rw(), vec(3'd6, 0, 0, 0, 0, 0, 0, 0, 0, 1, ill), "halt");
        end
    endtask

    task automatic run_trace();
        cyc_t c;
        logic [12:0] obs;
        while (trace.size() > 0) begin
            c = trace.pop_front();
            @(negedge clk);
            start       = c.start;
            bus.mem_rdy = c.rdy;
            zflag       = c.z;
            bus.instr   = c.instr;
            #1;
            obs = observed();
            n_checks++;
            if (obs !== c.exp) begin
                n_fail++;
                $display("FAIL %s @%0t: got %b expected %b (st/req/we/asel/lir/lpc/msel/alu/rfwe/halt/err)",
                         c.tag, $time, obs, c.exp);
            end
        end
    endtask

    task automatic check_zero(input string tag);
        logic [12:0] obs;
        obs = observed();
        n_checks++;
        if (obs !== 13'd0) begin
            n_fail++;
            $display("FAIL %s @%0t: got %b expected %b", tag, $time, obs, 13'd0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset       = 1'b1;
        start       = 1'b0;
        bus.mem_rdy = 1'b0;
        #1;
        check_zero("reset_state");
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        start       = 1'b0;
        zflag       = 1'b0;
        bus.mem_rdy = 1'b0;
        bus.instr   = '0;
        #1;
        check_zero("reset_async_no_edge");
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++)
            push(1'b0, rb(), rb(), rw(), vec(3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "idle_hold");
        run_trace();
    endtask

    task automatic test_alu();
        do_reset();
        push_start();
        add_instr(3'd0, 0, 0, 1'b0);
        add_instr(3'd0, 2, 0, 1'b1);
        run_trace();
    endtask

    task automatic test_load_store();
        do_reset();
        push_start();
        add_instr(3'd1, 0, 3, 1'b0);
        add_instr(3'd2, 1, 0, 1'b0);
        add_instr(3'd2, 0, 2, 1'b1);
        run_trace();
    endtask

    task automatic test_branch();
        do_reset();
        push_start();
        add_instr(3'd4, 0, 0, 1'b1);
        add_instr(3'd4, 0, 0, 1'b0);
        add_instr(3'd3, 1, 0, 1'b0);
        run_trace();
    endtask

    task automatic test_wait_boundary();
        do_reset();
        push_start();
        add_instr(3'd0, 15, 0, 1'b0);
        add_instr(3'd1, 0, 15, 1'b0);
        add_instr(3'd2, 15, 15, 1'b0);
        run_trace();
    endtask

    task automatic test_random();
        do_reset();
        push_start();
        for (int n = 0; n < 60; n++) begin
            logic [2:0] op;
            int fw, mw;
            op = 3'($urandom_range(0, 4));
            fw = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3);
            mw = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3);
            add_instr(op, fw, mw, rb());
        end
        run_trace();
    endtask

    task automatic test_timeout();
        do_reset();
        push_start();
        for (int i = 0; i < 16; i++)
            push(rb(), 1'b0, rb(), rw(), vec(3'd1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "fetch_timeout");
        for (int i = 0; i < 5; i++)
            push(1'b1, rb(), rb(), rw(), vec(3'd6, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1), "halt_timeout");
        run_trace();
    endtask

    task automatic test_reset_mid_mem();
        do_reset();
        push_start();
        push(1'b0, 1'b1, 1'b0, 16'h2000, vec(3'd1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0), "fetch_done");
        push(1'b0, 1'b0, 1'b0, rw(), vec(3'd2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "decode");
        push(1'b0, 1'b0, 1'b0, rw(), vec(3'd3, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), "exec");
        push(1'b0, 1'b0, 1'b0, rw(), vec(3'd4, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0), "mem_wait");
        push(1'b0, 1'b0, 1'b0, rw(), vec(3'd4, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0), "mem_wait");
        run_trace();
        #2;
        reset = 1'b1;
        #1;
        check_zero("reset_mid_mem");
        @(negedge clk);
        reset = 1'b0;
        push_start();
        add_instr(3'd0, 0, 0, 1'b0);
        run_trace();
    endtask

    task automatic test_halt_ops();
        do_reset();
        push_start();
        add_instr(3'd5, 0, 0, 1'b0);
        run_trace();
        do_reset();
        push_start();
        add_instr(3'd6, 1, 0, 1'b1);
        run_trace();
        do_reset();
        push_start();
        add_instr(3'd7, 0, 0, 1'b0);
        run_trace();
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_store();
        test_branch();
        test_wait_boundary();
        test_random();
        test_timeout();
        test_reset_mid_mem();
        test_halt_ops();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
